piso_shift_transmitter: RTL and testbench
=========================================

// Module: piso_shift_transmitter
// PURPOSE
//   Parallel-in serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and
//   shifts it out one bit per enabled clock, with a frame strobe and completion pulse.
//   Companion to the team's parallel shift-register storage: drives the serial end of the link
//   from a parallel word source. Supports gapless back-to-back words.
// PARAMETERS
//   WIDTH      4  word length in bits; legal range 2..32
//   MSB_FIRST  1  1: bit WIDTH-1 transmitted first; 0: bit 0 transmitted first
// PORTS
//   clock       in   1      single rising-edge clock for all state
//   reset       in   1      synchronous, active-high reset
//   data_in     in   WIDTH  parallel word; sampled only on accept
//   load_valid  in   1      source has a word on data_in
//   load_ready  out  1      block can accept a word this cycle
//   shift_en    in   1      bit-rate enable; the shifter advances only when high
//   serial_out  out  1      serial data, registered
//   frame_out   out  1      high while serial_out carries a valid bit, registered
//   busy        out  1      high in SHIFT state
//   done        out  1      1-cycle pulse: last bit of a word consumed, registered
// BEHAVIOUR
//   - Reset: state=IDLE, shreg=0, bit_cnt=0, serial_out=0, frame_out=0, done=0.
//     load_ready=0 while reset is high. Reset mid-word aborts it: no done pulse; the next edge
//     with reset low starts from IDLE.
//   - Accept = load_valid & load_ready, at a rising edge.
//   - load_ready (combinational) = !reset & (state==IDLE | (state==SHIFT & last & shift_en)),
//     where last = (bit_cnt==WIDTH-1).
//   - FSM states:
//     IDLE: serial_out=0, frame_out=0. Accept -> load shreg, bit_cnt=0, go to SHIFT. Next
//       cycle: frame_out=1 and serial_out=first bit, so first-bit latency is 1 cycle.
//     SHIFT: serial_out presents the current bit.
//       - shift_en=0: all state and outputs hold (stall); no timeout.
//       - shift_en=1 & !last: advance to the next bit, bit_cnt+1.
//       - shift_en=1 & last: done=1 next cycle.
//         - With accept in the same cycle: reload shreg, bit_cnt=0, stay in SHIFT. frame_out
//           stays high with no gap cycle.
//         - Without accept: go to IDLE, frame_out=0, serial_out=0.
//   - Word timing with shift_en tied high: accept at edge T; bits appear in cycles T+1..T+WIDTH;
//     done=1 in cycle T+WIDTH+1.
//   - Shifting: MSB_FIRST=1 shifts left, serial_out=shreg[WIDTH-1]. MSB_FIRST=0 shifts right,
//     serial_out=shreg[0]. Vacated bits fill with 0.
//   - bit_cnt width is $clog2(WIDTH). It never exceeds WIDTH-1 and wraps to 0 only on reload.
//   - load_valid while load_ready=0: ignored. data_in is not captured, and the source must hold
//     the word.
//   - done and frame_out may both be high in the same cycle (back-to-back case).
//   - busy = (state==SHIFT).
// TESTING (WIDTH=4 unless noted; shift_en=1 unless noted)
//   1 Reset: hold reset 2 cycles, drive load_valid=1 -> load_ready=0, serial_out=0,
//     frame_out=0, done=0 throughout.
//   2 Single word: accept 4'b1011 at T -> serial_out 1,0,1,1 in T+1..T+4, frame_out=1 in
//     T+1..T+4, done=1 only in T+5, load_ready=1 from T+5.
//   3 Back-to-back: 4'b1011 then 4'b0110, load_valid held -> 8 contiguous frame cycles
//     1,0,1,1,0,1,1,0 and two done pulses.
//   4 Stall: shift_en=0 for 3 cycles after the 2nd bit of 4'b1001 -> serial_out holds 0 for
//     those cycles; full sequence 1,0,0,1 still delivered; done is delayed by 3 cycles.
//   5 MSB_FIRST=0, WIDTH=8: accept 8'hA5 -> serial_out 1,0,1,0,0,1,0,1.
//   6 Reset mid-word after 2 bits of 4'b1111 -> outputs 0 next cycle, no done pulse; a new
//     word accepted after reset transmits correctly.

Source files
------------

// File: rtl/piso_shift_transmitter.sv
// Parallel-in serial-out transmitter. Accepts a WIDTH-bit word on a valid/ready handshake
// and shifts it out one bit per enabled clock, with a frame strobe and a done pulse.
module piso_shift_transmitter #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             frame_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx, shifted;
  logic [CW-1:0]    bit_cnt, bit_cnt_nx;
  logic             serial_nx, frame_nx, done_nx;
  logic             last, accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Handshake: a word transfers on a rising edge where load_valid and load_ready are both
  // high. load_ready never depends on load_valid; the source holds data_in until accepted.
  // A word can be taken in the same edge that consumes the previous word's last bit.
  always_comb begin
    last       = (bit_cnt == LAST_CNT);
    load_ready = !reset && ((state == IDLE) || ((state == SHIFT) && last && shift_en));
    accept     = load_valid && load_ready;
    shifted    = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    busy       = (state == SHIFT);

    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    serial_nx  = serial_out;
    frame_nx   = frame_out;
    done_nx    = 1'b0;

    case (state)
      IDLE: begin
        serial_nx = 1'b0;
        frame_nx  = 1'b0;
        if (accept) begin
          shreg_nx   = data_in;
          bit_cnt_nx = '0;
          serial_nx  = first_bit(data_in);
          frame_nx   = 1'b1;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (!last) begin
            shreg_nx   = shifted;
            bit_cnt_nx = bit_cnt + CW'(1);
            serial_nx  = first_bit(shifted);
          end else begin
            done_nx = 1'b1;
            if (accept) begin
              shreg_nx   = data_in;
              bit_cnt_nx = '0;
              serial_nx  = first_bit(data_in);
              frame_nx   = 1'b1;
            end else begin
              shreg_nx   = '0;
              bit_cnt_nx = '0;
              serial_nx  = 1'b0;
              frame_nx   = 1'b0;
              state_nx   = IDLE;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      serial_out <= 1'b0;
      frame_out  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      shreg      <= shreg_nx;
      bit_cnt    <= bit_cnt_nx;
      serial_out <= serial_nx;
      frame_out  <= frame_nx;
      done       <= done_nx;
    end
  end

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// Bench for piso_shift_transmitter: a 4-bit MSB-first instance and an 8-bit LSB-first
// instance, directed scenarios followed by a randomized run against a bit-queue model.
module tb_piso_shift_transmitter;

  logic       clock, reset;
  logic [3:0] a_data;
  logic       a_valid, a_ready, a_en, a_ser, a_frame, a_busy, a_done;
  logic [7:0] b_data;
  logic       b_valid, b_ready, b_en, b_ser, b_frame, b_busy, b_done;

  int n_checks = 0;
  int n_fail   = 0;

  piso_shift_transmitter #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
    .clock(clock), .reset(reset), .data_in(a_data), .load_valid(a_valid),
    .load_ready(a_ready), .shift_en(a_en), .serial_out(a_ser), .frame_out(a_frame),
    .busy(a_busy), .done(a_done)
  );

  piso_shift_transmitter #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clock(clock), .reset(reset), .data_in(b_data), .load_valid(b_valid),
    .load_ready(b_ready), .shift_en(b_en), .serial_out(b_ser), .frame_out(b_frame),
    .busy(b_busy), .done(b_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1; a_valid = 1'b1; a_data = 4'($urandom); a_en = 1'b1;
    b_valid = 1'b0; b_data = 8'h00; b_en = 1'b1;
    @(posedge clock); #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      n_checks++;
      if ({a_ready, a_ser, a_frame, a_done, a_busy} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_outputs c=%0d got ready,ser,frame,done,busy=%b expected 00000",
                 c, {a_ready, a_ser, a_frame, a_done, a_busy});
      end
      @(posedge clock); #1;
    end
    reset = 1'b0; a_valid = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] w;
    logic ef, es, ed;
    w = 4'b1011;
    a_data = w; a_valid = 1'b1; a_en = 1'b1;
    @(negedge clock);
    n_checks++;
    if (a_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_ready_idle got=%b expected=1", a_ready);
    end
    @(posedge clock); #1;
    a_valid = 1'b0; a_data = 4'($urandom);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      ef = (c <= 4);
      es = (c <= 4) ? w[4-c] : 1'b0;
      ed = (c == 5);
      n_checks++;
      if ({a_frame, a_ser, a_done} !== {ef, es, ed}) begin
        n_fail++;
        $display("FAIL single_word c=%0d got frame,ser,done=%b expected=%b",
                 c, {a_frame, a_ser, a_done}, {ef, es, ed});
      end
      if (c == 5) begin
        n_checks++;
        if (a_ready !== 1'b1) begin
          n_fail++; $display("FAIL single_ready_after got=%b expected=1", a_ready);
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w1, w2;
    logic ef, es, ed;
    w1 = 4'b1011; w2 = 4'b0110;
    a_data = w1; a_valid = 1'b1; a_en = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    a_data = w2;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      ef = (c <= 8);
      es = (c <= 4) ? w1[4-c] : (c <= 8) ? w2[8-c] : 1'b0;
      ed = (c == 5) || (c == 9);
      n_checks++;
      if ({a_frame, a_ser, a_done} !== {ef, es, ed}) begin
        n_fail++;
        $display("FAIL b2b_stream c=%0d got frame,ser,done=%b expected=%b",
                 c, {a_frame, a_ser, a_done}, {ef, es, ed});
      end
      if (c <= 4) begin
        n_checks++;
        if (a_ready !== (c == 4)) begin
          n_fail++; $display("FAIL b2b_ready c=%0d got=%b expected=%b", c, a_ready, (c == 4));
        end
      end
      @(posedge clock); #1;
      if (c == 4) a_valid = 1'b0;
    end
  endtask

  task automatic test_stall();
    logic [3:0] w;
    int idx, done_seen;
    logic done_exp, ef, es;
    w = 4'b1001; idx = 0; done_exp = 1'b0; done_seen = -1;
    a_data = w; a_valid = 1'b1; a_en = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    a_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      a_en = !((c >= 2) && (c <= 4));
      @(negedge clock);
      ef = (idx < 4);
      es = (idx < 4) ? w[3-idx] : 1'b0;
      n_checks++;
      if ({a_frame, a_ser, a_done} !== {ef, es, done_exp}) begin
        n_fail++;
        $display("FAIL stall_stream c=%0d got frame,ser,done=%b expected=%b",
                 c, {a_frame, a_ser, a_done}, {ef, es, done_exp});
      end
      if (!a_en) begin
        n_checks++;
        if ({a_busy, a_ready} !== 2'b10) begin
          n_fail++; $display("FAIL stall_busy c=%0d got busy,ready=%b expected=10", c, {a_busy, a_ready});
        end
      end
      if (a_done === 1'b1 && done_seen < 0) done_seen = c;
      done_exp = 1'b0;
      if (idx < 4 && a_en) begin
        idx++;
        if (idx == 4) done_exp = 1'b1;
      end
      @(posedge clock); #1;
    end
    a_en = 1'b1;
    n_checks++;
    if (done_seen != 5 + 3) begin
      n_fail++; $display("FAIL stall_done_cycle got=%0d expected=%0d", done_seen, 8);
    end
  endtask

  task automatic test_lsb8();
    logic [7:0] w;
    logic ef, es, ed;
    w = 8'hA5;
    b_data = w; b_valid = 1'b1; b_en = 1'b1;
    @(negedge clock);
    n_checks++;
    if (b_ready !== 1'b1) begin
      n_fail++; $display("FAIL lsb8_ready got=%b expected=1", b_ready);
    end
    @(posedge clock); #1;
    b_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      ef = (c <= 8);
      es = (c <= 8) ? w[c-1] : 1'b0;
      ed = (c == 9);
      n_checks++;
      if ({b_frame, b_ser, b_done} !== {ef, es, ed}) begin
        n_fail++;
        $display("FAIL lsb8_stream c=%0d got frame,ser,done=%b expected=%b",
                 c, {b_frame, b_ser, b_done}, {ef, es, ed});
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] w2;
    logic ef, es, ed;
    a_data = 4'b1111; a_valid = 1'b1; a_en = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    a_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock);
      n_checks++;
      if ({a_frame, a_ser} !== 2'b11) begin
        n_fail++; $display("FAIL rmid_pre c=%0d got frame,ser=%b expected=11", c, {a_frame, a_ser});
      end
      if (c == 2) begin
        reset = 1'b1;
        #1;
        n_checks++;
        if (a_ready !== 1'b0) begin
          n_fail++; $display("FAIL rmid_ready got=%b expected=0", a_ready);
        end
      end
      @(posedge clock); #1;
    end
    reset = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      @(negedge clock);
      n_checks++;
      if ({a_frame, a_ser, a_done, a_busy} !== 4'b0) begin
        n_fail++;
        $display("FAIL rmid_abort c=%0d got frame,ser,done,busy=%b expected=0000",
                 c, {a_frame, a_ser, a_done, a_busy});
      end
      @(posedge clock); #1;
    end
    w2 = 4'($urandom_range(0, 15));
    a_data = w2; a_valid = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    a_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      ef = (c <= 4);
      es = (c <= 4) ? w2[4-c] : 1'b0;
      ed = (c == 5);
      n_checks++;
      if ({a_frame, a_ser, a_done} !== {ef, es, ed}) begin
        n_fail++;
        $display("FAIL rmid_after c=%0d word=%b got frame,ser,done=%b expected=%b",
                 c, w2, {a_frame, a_ser, a_done}, {ef, es, ed});
      end
      @(posedge clock); #1;
    end
  endtask

  // Model: a queue of bits still owed on the line; a bit leaves when it is on the line
  // during an enabled edge, and every fourth bit leaving schedules a done pulse.
  task automatic test_random();
    logic exp_q[$];
    int consumed, n_acc;
    logic done_pend, hold, accepted, exp_ready;
    consumed = 0; n_acc = 0; done_pend = 1'b0; hold = 1'b0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (!hold) begin
        a_valid = (cyc < 380) && ($urandom_range(0, 2) != 0);
        a_data  = 4'($urandom);
      end
      a_en = (cyc < 380) ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clock);
      exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && a_en);
      n_checks++;
      if ({a_frame, a_done, a_ready} !== {(exp_q.size() != 0), done_pend, exp_ready}) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc=%0d got frame,done,ready=%b expected=%b", cyc,
                 {a_frame, a_done, a_ready}, {(exp_q.size() != 0), done_pend, exp_ready});
      end
      if (exp_q.size() != 0) begin
        n_checks++;
        if (a_ser !== exp_q[0]) begin
          n_fail++; $display("FAIL rand_serial cyc=%0d got=%b expected=%b", cyc, a_ser, exp_q[0]);
        end
      end
      accepted = a_valid && a_ready;
      done_pend = 1'b0;
      if (exp_q.size() != 0 && a_en) begin
        void'(exp_q.pop_front());
        consumed++;
        done_pend = (consumed % 4 == 0);
      end
      if (accepted) begin
        n_acc++;
        for (int i = 3; i >= 0; i--) exp_q.push_back(a_data[i]);
      end
      hold = a_valid && !accepted;
      @(posedge clock); #1;
    end
    a_valid = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || consumed != 4 * n_acc) begin
      n_fail++;
      $display("FAIL rand_drain got pending=%0d consumed=%0d expected pending=0 consumed=%0d",
               exp_q.size(), consumed, 4 * n_acc);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_lsb8();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
